// File: rtl/sn_reg_ctrl.sv
// Decodes SN76489-style latch/data write bytes into tone, attenuation and noise registers.
// Registers update on the accepting edge; ready is held low for WRITE_CYCLES cycles after each write.
module sn_reg_ctrl #(
  parameter int WRITE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic [9:0] freq0,
  output logic [9:0] freq1,
  output logic [9:0] freq2,
  output logic [3:0] atten0,
  output logic [3:0] atten1,
  output logic [3:0] atten2,
  output logic [3:0] atten3,
  output logic [2:0] noise_ctrl,
  output logic       noise_reset
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUSY     = 1'b1;
  localparam logic [7:0] CNT_LOAD = 8'(WRITE_CYCLES - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] latch_q, latch_d;
  logic [9:0] freq0_q, freq0_d, freq1_q, freq1_d, freq2_q, freq2_d;
  logic [3:0] atten0_q, atten0_d, atten1_q, atten1_d;
  logic [3:0] atten2_q, atten2_d, atten3_q, atten3_d;
  logic [2:0] noise_ctrl_q, noise_ctrl_d;
  logic       noise_reset_q, noise_reset_d;

  logic       accept;
  logic       is_latch;
  logic [2:0] tgt;

  assign ready    = (state_q == IDLE);
  assign accept   = wr_en & ready;
  assign is_latch = data_in[7];
  // A latch byte addresses the register it names; a data byte reuses the last latch.
  assign tgt      = is_latch ? data_in[6:4] : latch_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    latch_d       = latch_q;
    freq0_d       = freq0_q;
    freq1_d       = freq1_q;
    freq2_d       = freq2_q;
    atten0_d      = atten0_q;
    atten1_d      = atten1_q;
    atten2_d      = atten2_q;
    atten3_d      = atten3_q;
    noise_ctrl_d  = noise_ctrl_q;
    noise_reset_d = 1'b0;

    if (state_q == IDLE) begin
      if (accept) begin
        state_d = BUSY;
        cnt_d   = CNT_LOAD;
      end
    end else begin
      if (cnt_q == 8'd0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    if (accept) begin
      if (is_latch) begin
        latch_d = data_in[6:4];
      end
      if (tgt[0]) begin
        case (tgt[2:1])
          2'd0:    atten0_d = data_in[3:0];
          2'd1:    atten1_d = data_in[3:0];
          2'd2:    atten2_d = data_in[3:0];
          default: atten3_d = data_in[3:0];
        endcase
      end else begin
        // Latch bytes carry the low nibble of a divider, data bytes the upper six bits.
        case (tgt[2:1])
          2'd0: freq0_d = is_latch ? {freq0_q[9:4], data_in[3:0]} : {data_in[5:0], freq0_q[3:0]};
          2'd1: freq1_d = is_latch ? {freq1_q[9:4], data_in[3:0]} : {data_in[5:0], freq1_q[3:0]};
          2'd2: freq2_d = is_latch ? {freq2_q[9:4], data_in[3:0]} : {data_in[5:0], freq2_q[3:0]};
          default: begin
            noise_ctrl_d  = data_in[2:0];
            noise_reset_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      latch_q       <= 3'b000;
      freq0_q       <= 10'd0;
      freq1_q       <= 10'd0;
      freq2_q       <= 10'd0;
      atten0_q      <= 4'hF;
      atten1_q      <= 4'hF;
      atten2_q      <= 4'hF;
      atten3_q      <= 4'hF;
      noise_ctrl_q  <= 3'd0;
      noise_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      latch_q       <= latch_d;
      freq0_q       <= freq0_d;
      freq1_q       <= freq1_d;
      freq2_q       <= freq2_d;
      atten0_q      <= atten0_d;
      atten1_q      <= atten1_d;
      atten2_q      <= atten2_d;
      atten3_q      <= atten3_d;
      noise_ctrl_q  <= noise_ctrl_d;
      noise_reset_q <= noise_reset_d;
    end
  end

  assign freq0       = freq0_q;
  assign freq1       = freq1_q;
  assign freq2       = freq2_q;
  assign atten0      = atten0_q;
  assign atten1      = atten1_q;
  assign atten2      = atten2_q;
  assign atten3      = atten3_q;
  assign noise_ctrl  = noise_ctrl_q;
  assign noise_reset = noise_reset_q;

endmodule

// File: tb/tb_sn_reg_ctrl.sv
// Bench for sn_reg_ctrl: write table with hand-derived register images, plus busy-drop and reset corner sequences.
module tb_sn_reg_ctrl;

  localparam int WC = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       ready;
  logic [9:0] freq0, freq1, freq2;
  logic [3:0] atten0, atten1, atten2, atten3;
  logic [2:0] noise_ctrl;
  logic       noise_reset;

  sn_reg_ctrl #(.WRITE_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .ready(ready),
    .freq0(freq0), .freq1(freq1), .freq2(freq2),
    .atten0(atten0), .atten1(atten1), .atten2(atten2), .atten3(atten3),
    .noise_ctrl(noise_ctrl), .noise_reset(noise_reset)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] f0, f1, f2;
    logic [3:0] a0, a1, a2, a3;
    logic [2:0] n;
    logic       nr;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t tbl[14];

  function automatic exp_t mk(logic [9:0] f0, logic [9:0] f1, logic [9:0] f2,
                              logic [3:0] a0, logic [3:0] a1, logic [3:0] a2, logic [3:0] a3,
                              logic [2:0] n, logic nr);
    exp_t e;
    e.f0 = f0; e.f1 = f1; e.f2 = f2;
    e.a0 = a0; e.a1 = a1; e.a2 = a2; e.a3 = a3;
    e.n = n; e.nr = nr;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_outs(input string tag, input exp_t e, input logic rdy);
    check({tag, ".ready"}, 32'(ready), 32'(rdy));
    check({tag, ".freq0"}, 32'(freq0), 32'(e.f0));
    check({tag, ".freq1"}, 32'(freq1), 32'(e.f1));
    check({tag, ".freq2"}, 32'(freq2), 32'(e.f2));
    check({tag, ".atten0"}, 32'(atten0), 32'(e.a0));
    check({tag, ".atten1"}, 32'(atten1), 32'(e.a1));
    check({tag, ".atten2"}, 32'(atten2), 32'(e.a2));
    check({tag, ".atten3"}, 32'(atten3), 32'(e.a3));
    check({tag, ".noise_ctrl"}, 32'(noise_ctrl), 32'(e.n));
    check({tag, ".noise_reset"}, 32'(noise_reset), 32'(e.nr));
  endtask

  // Called at a sample point where ready is high; returns at the first sample where ready is high again.
  task automatic do_write(input string tag, input logic [7:0] d, input exp_t e,
                          input bit hold, input logic [7:0] hold_d);
    int   low;
    exp_t got;
    wr_en   = 1'b1;
    data_in = d;
    sb_q.push_back(e);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    cmp_outs(tag, got, 1'b0);
    if (hold) data_in = hold_d;
    else wr_en = 1'b0;
    @(posedge clk); #1;
    got.nr = 1'b0;
    cmp_outs({tag, ".after"}, got, 1'b0);
    low = 1;
    while (!ready && low < 300) begin
      low++;
      if (hold) check({tag, ".atten2_busy"}, 32'(atten2), 32'(got.a2));
      @(posedge clk); #1;
    end
    check({tag, ".busy_cycles"}, 32'(low), 32'(WC));
  endtask

  exp_t rst_e;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_e = mk(10'h000, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0);
    tbl[0]  = '{d: 8'h8E, e: mk(10'h00E, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0)};
    tbl[1]  = '{d: 8'h3F, e: mk(10'h3FE, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0)};
    tbl[2]  = '{d: 8'hA3, e: mk(10'h3FE, 10'h003, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0)};
    tbl[3]  = '{d: 8'h01, e: mk(10'h3FE, 10'h013, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0)};
    tbl[4]  = '{d: 8'h02, e: mk(10'h3FE, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0)};
    tbl[5]  = '{d: 8'hE6, e: mk(10'h3FE, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd6, 1'b1)};
    tbl[6]  = '{d: 8'h05, e: mk(10'h3FE, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd5, 1'b1)};
    tbl[7]  = '{d: 8'hF0, e: mk(10'h3FE, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'h0, 3'd5, 1'b0)};
    tbl[8]  = '{d: 8'h8A, e: mk(10'h3FA, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'h0, 3'd5, 1'b0)};
    tbl[9]  = '{d: 8'h7F, e: mk(10'h3FA, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'h0, 3'd5, 1'b0)};
    tbl[10] = '{d: 8'hEF, e: mk(10'h3FA, 10'h023, 10'h000, 4'hF, 4'hF, 4'hF, 4'h0, 3'd7, 1'b1)};
    tbl[11] = '{d: 8'hC9, e: mk(10'h3FA, 10'h023, 10'h009, 4'hF, 4'hF, 4'hF, 4'h0, 3'd7, 1'b0)};
    tbl[12] = '{d: 8'hB7, e: mk(10'h3FA, 10'h023, 10'h009, 4'hF, 4'h7, 4'hF, 4'h0, 3'd7, 1'b0)};
    tbl[13] = '{d: 8'h03, e: mk(10'h3FA, 10'h023, 10'h009, 4'hF, 4'h3, 4'hF, 4'h0, 3'd7, 1'b0)};

    // Reset held two edges with a write pending: reset must win.
    rst = 1'b1; wr_en = 1'b1; data_in = 8'h90;
    repeat (2) @(posedge clk);
    #1;
    cmp_outs("reset", rst_e, 1'b1);
    rst = 1'b0; wr_en = 1'b0; data_in = 8'h00;

    for (int i = 0; i < 14; i++) begin
      do_write($sformatf("vec%0d", i), tbl[i].d, tbl[i].e, 1'b0, 8'h00);
    end

    // Writes offered while busy are dropped; the first one after ready returns lands.
    do_write("busy_drop", 8'hD5,
             mk(10'h3FA, 10'h023, 10'h009, 4'hF, 4'h3, 4'h5, 4'h0, 3'd7, 1'b0), 1'b1, 8'hDA);
    do_write("after_busy", 8'hDA,
             mk(10'h3FA, 10'h023, 10'h009, 4'hF, 4'h3, 4'hA, 4'h0, 3'd7, 1'b0), 1'b0, 8'h00);

    // Reset ten cycles into a busy window.
    wr_en = 1'b1; data_in = 8'h8E;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("midbusy.freq0", 32'(freq0), 32'h3FE);
    repeat (9) @(posedge clk);
    #1;
    check("midbusy.ready_low", 32'(ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_outs("midbusy_reset", rst_e, 1'b1);
    do_write("post_reset", 8'h81,
             mk(10'h001, 10'h000, 10'h000, 4'hF, 4'hF, 4'hF, 4'hF, 3'd0, 1'b0), 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
